// File: rtl/conv23_mac_pool.sv
// 3x3 conv multiply-accumulate over CH channels, bias + saturate + ReLU,
// then 2x2 max-pool; one pooled pixel written per four conv windows.
module conv23_mac_pool #(
  parameter int unsigned CH     = 112,
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned HEIGHT = 18,
  parameter int unsigned FRAC   = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iValid,
  input  logic [15:0] iData,
  input  logic [15:0] iWeight,
  input  logic [15:0] iBias,
  output logic        oReady,
  output logic        oValid,
  output logic [15:0] oData,
  output logic [8:0]  oWr_ADDR,
  output logic        oDONE
);

  localparam int unsigned OW     = WIDTH >> 1;
  localparam int unsigned OH     = HEIGHT >> 1;
  localparam int unsigned CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned I_W    = (OW > 1) ? $clog2(OW) : 1;
  localparam int unsigned J_W    = (OH > 1) ? $clog2(OH) : 1;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned ACC_W  = 42;

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_ACT, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                tap_q, tap_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [1:0]                pos_q, pos_d;
  logic [I_W-1:0]            col_q, col_d;
  logic [J_W-1:0]            row_q, row_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic                      pvld_q, pvld_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [15:0]               pool_q, pool_d;
  logic                      rdy_q, rdy_d;
  logic                      ovld_q, ovld_d;
  logic                      done_q, done_d;
  logic [15:0]               odata_q, odata_d;
  logic [8:0]                addr_q, addr_d;

  logic                      xfer;
  logic                      last_col, last_row;
  logic signed [ACC_W-1:0]   biased;
  logic [15:0]               relu;

  assign xfer     = iValid && (state_q == S_ACC);
  assign last_col = (col_q == I_W'(OW - 1));
  assign last_row = (row_q == J_W'(OH - 1));

  // Drop fraction bits, add bias, clamp to int16; anything negative becomes 0.
  always_comb begin
    biased = (acc_q >>> FRAC) + ACC_W'($signed(iBias));
    if (biased > 42'sd32767)   relu = 16'h7fff;
    else if (biased < 42'sd0)  relu = 16'h0000;
    else                       relu = 16'(biased);
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    ch_d    = ch_q;
    pos_d   = pos_q;
    col_d   = col_q;
    row_d   = row_q;
    prod_d  = prod_q;
    pvld_d  = 1'b0;
    acc_d   = acc_q;
    pool_d  = pool_q;
    ovld_d  = 1'b0;
    done_d  = 1'b0;
    odata_d = odata_q;
    addr_d  = addr_q;

    if (xfer) begin
      prod_d = PROD_W'($signed(iData)) * PROD_W'($signed(iWeight));
      pvld_d = 1'b1;
    end
    if (pvld_q) acc_d = acc_q + ACC_W'(prod_q);

    case (state_q)
      S_ACC: begin
        if (xfer) begin
          if (tap_q == 4'd8) begin
            tap_d = 4'd0;
            if (ch_q == CH_W'(CH - 1)) begin
              ch_d    = '0;
              state_d = S_DRAIN;
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end else begin
            tap_d = tap_q + 4'd1;
          end
        end
      end
      // Lets the final product land in the accumulator.
      S_DRAIN: state_d = S_ACT;
      S_ACT: begin
        pool_d = ((pos_q == 2'd0) || (relu > pool_q)) ? relu : pool_q;
        acc_d  = '0;
        if (pos_q == 2'd3) begin
          pos_d   = 2'd0;
          state_d = S_OUT;
          ovld_d  = 1'b1;
          done_d  = last_col && last_row;
          odata_d = pool_d;
          addr_d  = 9'(col_q) + 9'(row_q) * 9'(OW);
        end else begin
          pos_d   = pos_q + 2'd1;
          state_d = S_ACC;
        end
      end
      S_OUT: begin
        state_d = S_ACC;
        if (last_col) begin
          col_d = '0;
          row_d = last_row ? '0 : row_q + J_W'(1);
        end else begin
          col_d = col_q + I_W'(1);
        end
      end
      default: state_d = S_ACC;
    endcase

    rdy_d = (state_d == S_ACC);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_ACC;
      tap_q   <= '0;
      ch_q    <= '0;
      pos_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      prod_q  <= '0;
      pvld_q  <= 1'b0;
      acc_q   <= '0;
      pool_q  <= '0;
      rdy_q   <= 1'b1;
      ovld_q  <= 1'b0;
      done_q  <= 1'b0;
      odata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      ch_q    <= ch_d;
      pos_q   <= pos_d;
      col_q   <= col_d;
      row_q   <= row_d;
      prod_q  <= prod_d;
      pvld_q  <= pvld_d;
      acc_q   <= acc_d;
      pool_q  <= pool_d;
      rdy_q   <= rdy_d;
      ovld_q  <= ovld_d;
      done_q  <= done_d;
      odata_q <= odata_d;
      addr_q  <= addr_d;
    end
  end

  assign oReady   = rdy_q;
  assign oValid   = ovld_q;
  assign oDONE    = done_q;
  assign oData    = odata_q;
  assign oWr_ADDR = addr_q;

endmodule

// File: tb/tb_conv23_mac_pool.sv
// Directed bench: small 4x4 single-channel instance plus a CH=112 instance
// used for the saturation case; both share the input stream.
module tb_conv23_mac_pool;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iValid;
  logic [15:0] iData, iWeight, iBias;

  logic        a_rdy, a_vld, a_done;
  logic [15:0] a_data;
  logic [8:0]  a_addr;
  logic        b_rdy, b_vld, b_done;
  logic [15:0] b_data;
  logic [8:0]  b_addr;

  logic        sel;
  logic        rdy, vld, done;
  logic [15:0] odat;
  logic [8:0]  oadr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] pd0 [4];
  logic [15:0] pdr [4];

  conv23_mac_pool #(.CH(1), .WIDTH(4), .HEIGHT(4), .FRAC(8)) dut (
    .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iData(iData),
    .iWeight(iWeight), .iBias(iBias), .oReady(a_rdy), .oValid(a_vld),
    .oData(a_data), .oWr_ADDR(a_addr), .oDONE(a_done)
  );

  conv23_mac_pool #(.CH(112), .WIDTH(2), .HEIGHT(2), .FRAC(8)) dut_sat (
    .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iData(iData),
    .iWeight(iWeight), .iBias(iBias), .oReady(b_rdy), .oValid(b_vld),
    .oData(b_data), .oWr_ADDR(b_addr), .oDONE(b_done)
  );

  assign rdy  = sel ? b_rdy  : a_rdy;
  assign vld  = sel ? b_vld  : a_vld;
  assign done = sel ? b_done : a_done;
  assign odat = sel ? b_data : a_data;
  assign oadr = sel ? b_addr : a_addr;

  always #5 iCLK = ~iCLK;

  task automatic apply_reset();
    @(negedge iCLK);
    iRST   = 1'b1;
    iValid = 1'b0;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
  endtask

  // One conv-window group (4 pool positions); tap 0 uses pd0[p], taps 1..8 use pdr[p].
  task automatic drive_window(input string nm, input int ch, input logic [15:0] w,
                              input bit gap, input int stop_after,
                              input logic [15:0] exp_data, input logic [8:0] exp_addr,
                              input logic exp_done);
    int nx;
    int guard;
    bit tog;
    bit ok;
    nx  = 0;
    tog = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < ch; c++) begin
        for (int k = 0; k < 9; k++) begin
          if (stop_after >= 0 && nx == stop_after) return;
          ok    = 1'b0;
          guard = 0;
          while (!ok && guard < 8) begin
            @(negedge iCLK);
            iData   = (k == 0) ? pd0[p] : pdr[p];
            iWeight = w;
            iValid  = gap ? tog : 1'b1;
            tog     = ~tog;
            if (iValid && rdy) ok = 1'b1;
            else guard++;
          end
          if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL %s accept: transfer %0d not accepted within 8 cycles", nm, nx);
            iValid = 1'b0;
            return;
          end
          @(posedge iCLK);
          nx++;
        end
      end
      // Window tail: offered junk must be refused while not ready.
      @(negedge iCLK);
      iValid = 1'b1; iData = 16'h7fff; iWeight = 16'h7fff;
      n_checks++;
      if (rdy !== 1'b0 || vld !== 1'b0) begin
        n_fail++;
        $display("FAIL %s t+1 p%0d: rdy=%b vld=%b, need rdy=0 vld=0", nm, p, rdy, vld);
      end
      @(negedge iCLK);
      iValid = 1'b0;
      n_checks++;
      if (rdy !== 1'b0 || vld !== 1'b0) begin
        n_fail++;
        $display("FAIL %s t+2 p%0d: rdy=%b vld=%b, need rdy=0 vld=0", nm, p, rdy, vld);
      end
      @(negedge iCLK);
      if (p < 3) begin
        n_checks++;
        if (rdy !== 1'b1 || vld !== 1'b0) begin
          n_fail++;
          $display("FAIL %s t+3 p%0d: rdy=%b vld=%b, need rdy=1 vld=0", nm, p, rdy, vld);
        end
      end else begin
        n_checks++;
        if (vld !== 1'b1 || rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s out strobe: vld=%b rdy=%b, need vld=1 rdy=0", nm, vld, rdy);
        end
        n_checks++;
        if (odat !== exp_data) begin
          n_fail++;
          $display("FAIL %s data: got %0d, need %0d", nm, odat, exp_data);
        end
        n_checks++;
        if (oadr !== exp_addr) begin
          n_fail++;
          $display("FAIL %s addr: got %0d, need %0d", nm, oadr, exp_addr);
        end
        n_checks++;
        if (done !== exp_done) begin
          n_fail++;
          $display("FAIL %s done: got %b, need %b", nm, done, exp_done);
        end
        @(negedge iCLK);
        n_checks++;
        if (rdy !== 1'b1 || vld !== 1'b0 || done !== 1'b0 || odat !== exp_data) begin
          n_fail++;
          $display("FAIL %s t+4: rdy=%b vld=%b done=%b data=%0d, need 1 0 0 %0d",
                   nm, rdy, vld, done, odat, exp_data);
        end
      end
    end
  endtask

  task automatic uniform_frame(input string nm, input bit gap);
    iBias = 16'd0;
    for (int p = 0; p < 4; p++) begin
      pd0[p] = 16'd256;
      pdr[p] = 16'd256;
    end
    for (int n = 0; n < 4; n++)
      drive_window(nm, 1, 16'd256, gap, -1, 16'd2304, 9'(n), n == 3);
  endtask

  task automatic test_reset();
    @(negedge iCLK);
    iRST = 1'b1; iValid = 1'b0;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    n_checks++;
    if (a_vld !== 1'b0 || a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset strobes: vld=%b done=%b, need 0 0", a_vld, a_done);
    end
    n_checks++;
    if (a_data !== 16'd0 || a_addr !== 9'd0) begin
      n_fail++;
      $display("FAIL reset outputs: data=%0d addr=%0d, need 0 0", a_data, a_addr);
    end
    iRST = 1'b0;
    @(negedge iCLK);
    n_checks++;
    if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset ready: a=%b b=%b, need 1 1", a_rdy, b_rdy);
    end
  endtask

  task automatic test_uniform();
    uniform_frame("uniform", 1'b0);
  endtask

  task automatic test_max_pool();
    iBias = 16'd0;
    pd0[0] = 16'd100; pd0[1] = 16'd700; pd0[2] = 16'd300; pd0[3] = 16'd200;
    for (int p = 0; p < 4; p++) pdr[p] = 16'd0;
    drive_window("max_pool", 1, 16'd256, 1'b0, -1, 16'd700, 9'd0, 1'b0);
  endtask

  task automatic test_relu_bias();
    iBias = 16'd0;
    for (int p = 0; p < 4; p++) begin
      pd0[p] = 16'hff00;
      pdr[p] = 16'hff00;
    end
    drive_window("relu_neg", 1, 16'd256, 1'b0, -1, 16'd0, 9'd1, 1'b0);
    iBias = 16'd5;
    for (int p = 0; p < 4; p++) begin
      pd0[p] = 16'd0;
      pdr[p] = 16'd0;
    end
    drive_window("bias_only", 1, 16'd256, 1'b0, -1, 16'd5, 9'd2, 1'b0);
  endtask

  task automatic test_valid_gaps();
    apply_reset();
    uniform_frame("valid_gaps", 1'b1);
  endtask

  task automatic test_reset_mid();
    iBias = 16'd0;
    for (int p = 0; p < 4; p++) begin
      pd0[p] = 16'd256;
      pdr[p] = 16'd256;
    end
    drive_window("mid_w0", 1, 16'd256, 1'b0, -1, 16'd2304, 9'd0, 1'b0);
    drive_window("mid_w1", 1, 16'd256, 1'b0, -1, 16'd2304, 9'd1, 1'b0);
    drive_window("mid_w2", 1, 16'd256, 1'b0, 20, 16'd0, 9'd0, 1'b0);
    apply_reset();
    n_checks++;
    if (a_data !== 16'd0 || a_addr !== 9'd0 || a_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid reset: data=%0d addr=%0d rdy=%b, need 0 0 1", a_data, a_addr, a_rdy);
    end
    uniform_frame("after_reset", 1'b0);
  endtask

  task automatic test_saturation();
    apply_reset();
    sel   = 1'b1;
    iBias = 16'd0;
    for (int p = 0; p < 4; p++) begin
      pd0[p] = 16'h7fff;
      pdr[p] = 16'h7fff;
    end
    drive_window("saturate", 112, 16'h7fff, 1'b0, -1, 16'd32767, 9'd0, 1'b1);
    sel = 1'b0;
  endtask

  initial begin
    iRST = 1'b1; iValid = 1'b0; sel = 1'b0;
    iData = '0; iWeight = '0; iBias = '0;
    test_reset();
    test_uniform();
    test_max_pool();
    test_relu_bias();
    test_valid_gaps();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
